// File: rtl/lock_pkg.sv
// Shared definitions for the lock sequencer: FSM state encoding, LED and
// 7-segment patterns, and a counter-width helper used by the top and by
// the button debouncer.
package lock_pkg;

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      STAGE2  = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } lock_state_e;

   // 7-segment patterns: "C", "1", "0", "E"
   localparam logic [8:0] SEG_C = 9'h039;
   localparam logic [8:0] SEG_1 = 9'h006;
   localparam logic [8:0] SEG_0 = 9'h03f;
   localparam logic [8:0] SEG_E = 9'h079;

   // {lock1, lock2}: 1 = locked, 0 = that stage open
   localparam logic [1:0] LED_LOCKED = 2'b11;
   localparam logic [1:0] LED_STAGE2 = 2'b01;
   localparam logic [1:0] LED_OPEN   = 2'b00;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lock_btn_debounce.sv
// Level debouncer for one synchronized, active-low button.
// The output follows the input only after the input has held a new level
// for DEBOUNCE_CYCLES consecutive clocks; shorter bounces are swallowed.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (output resets to released)
//   btn_i   in  synchronized button level
//   btn_o   out debounced button level
module lock_btn_debounce
   import lock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic btn_o
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Down-counter reloads whenever the input agrees with the stable level;
   // reaching zero while it still disagrees commits the new level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = CNT_LOAD;
      if (btn_i != stable_q) begin
         if (cnt_q == '0) begin
            stable_d = btn_i;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= 1'b1;
         cnt_q    <= CNT_LOAD;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign btn_o = stable_q;

endmodule

// File: rtl/lock_sequencer.sv
// Two-stage password lock controller with failed-attempt lockout and
// auto-relock. Single Moore FSM; all outputs decode registered state.
// Optional macro LOCK_DEBOUNCE_EN inserts a debouncer on each button.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOCKED  | waiting for stage-1 password on btn1 (led 11, "C")
// STAGE2  | stage 1 passed, waiting for stage-2 password on btn2 (led 01, "1")
// OPEN    | both stages passed; relocks on btn1 or timeout (led 00, "0")
// LOCKOUT | too many failures; presses ignored until timeout (led 11, "E")
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key[3:0]    in   password switches (asynchronous)
//   btn1        in   stage-1 confirm, active-low (asynchronous)
//   btn2        in   stage-2 confirm, active-low (asynchronous)
//   led[1:0]    out  {lock1, lock2}
//   seg_led[8:0]out  7-segment pattern
//   alarm       out  high while in LOCKOUT
//   tries_left  out  MAX_TRIES minus current fail count
module lock_sequencer
   import lock_pkg::*;
#(
   parameter logic [3:0]  PWD1            = 4'b1010,
   parameter logic [3:0]  PWD2            = 4'b0101,
   parameter int unsigned MAX_TRIES       = 3,
   parameter int unsigned LOCKOUT_CYCLES  = 50_000_000,
   parameter int unsigned OPEN_CYCLES     = 250_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key,
   input  logic       btn1,
   input  logic       btn2,
   output logic [1:0] led,
   output logic [8:0] seg_led,
   output logic       alarm,
   output logic [3:0] tries_left
);

   localparam int TW = cnt_w(max_u(LOCKOUT_CYCLES, OPEN_CYCLES));
   localparam logic [TW-1:0] OPEN_TC    = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_TC = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]    MAX_T      = 4'(MAX_TRIES);

   // ---------------------------------------------------------------
   // Input conditioning. Index 0 = btn1, index 1 = btn2.
   // ---------------------------------------------------------------
   logic [3:0] key_s1_q, key_s2_q;
   logic [1:0] btn_s1_q, btn_s2_q;
   logic [1:0] btn_lvl;
   logic [1:0] btn_prev_q;
   logic [1:0] warm_q;
   logic [1:0] armed_q, armed_d;
   logic [1:0] press;

`ifdef LOCK_DEBOUNCE_EN
   lock_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn1 (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_s2_q[0]),
      .btn_o (btn_lvl[0])
   );
   lock_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn2 (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_s2_q[1]),
      .btn_o (btn_lvl[1])
   );
`else
   logic unused_deb;
   assign unused_deb = ^DEBOUNCE_CYCLES;
   assign btn_lvl    = btn_s2_q;
`endif

   // The synchronizer resets to "released", so a button held low through
   // reset release would look like a fresh falling edge. A button is only
   // armed once its synchronized pin has been seen high after the chain
   // has filled with real samples (warm_q), which suppresses that edge.
   assign armed_d = armed_q | ({2{warm_q[1]}} & btn_s2_q);
   assign press   = armed_q & btn_prev_q & ~btn_lvl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q   <= 4'hF;
         key_s2_q   <= 4'hF;
         btn_s1_q   <= 2'b11;
         btn_s2_q   <= 2'b11;
         btn_prev_q <= 2'b11;
         warm_q     <= 2'b00;
         armed_q    <= 2'b00;
      end else begin
         key_s1_q   <= key;
         key_s2_q   <= key_s1_q;
         btn_s1_q   <= {btn2, btn1};
         btn_s2_q   <= btn_s1_q;
         btn_prev_q <= btn_lvl;
         warm_q     <= {warm_q[0], 1'b1};
         armed_q    <= armed_d;
      end
   end

   // ---------------------------------------------------------------
   // Sequencing FSM
   // ---------------------------------------------------------------
   lock_state_e   state_q, state_d;
   logic [3:0]    fail_cnt_q, fail_cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    fail_inc;
   lock_state_e   fail_dest;

   assign fail_inc  = (fail_cnt_q == 4'hF) ? fail_cnt_q : fail_cnt_q + 4'd1;
   assign fail_dest = (fail_inc >= MAX_T) ? LOCKOUT : LOCKED;

   // Timer defaults to zero so every state entry starts it cleared; only
   // OPEN and LOCKOUT let it advance while they stay put.
   always_comb begin
      state_d    = state_q;
      fail_cnt_d = fail_cnt_q;
      timer_d    = '0;
      unique case (state_q)
         LOCKED: begin
            if (press[0]) begin
               if (key_s2_q == PWD1) begin
                  state_d = STAGE2;
               end else begin
                  fail_cnt_d = fail_inc;
                  state_d    = fail_dest;
               end
            end
         end
         STAGE2: begin
            // btn1 has priority; a simultaneous btn2 press is dropped
            if (press[0]) begin
               if (key_s2_q != PWD1) begin
                  fail_cnt_d = fail_inc;
                  state_d    = fail_dest;
               end
            end else if (press[1]) begin
               if (key_s2_q == PWD2) begin
                  state_d    = OPEN;
                  fail_cnt_d = '0;
               end else begin
                  fail_cnt_d = fail_inc;
                  state_d    = fail_dest;
               end
            end
         end
         OPEN: begin
            if (press[0] || timer_q == OPEN_TC) begin
               state_d = LOCKED;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         LOCKOUT: begin
            if (timer_q == LOCKOUT_TC) begin
               state_d    = LOCKED;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = LOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LOCKED;
         fail_cnt_q <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         fail_cnt_q <= fail_cnt_d;
         timer_q    <= timer_d;
      end
   end

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   always_comb begin
      led     = LED_LOCKED;
      seg_led = SEG_C;
      alarm   = 1'b0;
      unique case (state_q)
         LOCKED: begin
            led     = LED_LOCKED;
            seg_led = SEG_C;
         end
         STAGE2: begin
            led     = LED_STAGE2;
            seg_led = SEG_1;
         end
         OPEN: begin
            led     = LED_OPEN;
            seg_led = SEG_0;
         end
         LOCKOUT: begin
            led     = LED_LOCKED;
            seg_led = SEG_E;
            alarm   = 1'b1;
         end
         default: begin
            led     = LED_LOCKED;
            seg_led = SEG_C;
         end
      endcase
   end

   assign tries_left = MAX_T - fail_cnt_q;

endmodule
